// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Purpose : groups the control requests and status outputs of pc_sequencer
//           into one bundle. clk and reset stay plain module ports.
// Modports:
//   master - the controller side: drives start/stall/redirect/trap/halt
//            requests and observes pc and EPC status.
//   slave  - the sequencer side: receives the requests and drives status.
// Signals :
//   start, stall                    run enable / hold pc this cycle
//   redirect_valid, redirect_target branch or jump target
//   trap_req, trap_ret, halt_req    trap entry / trap return / halt
//   pc_out, pc_valid                current pc, pc valid this cycle
//   epc_out, trap_depth             top return address, valid EPC entries
//   trap_err, halted                sticky error flag, HALT indication
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int XLEN      = 32,
  parameter int EPC_DEPTH = 4
);

  localparam int DW = $clog2(EPC_DEPTH + 1);

  logic            start;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_req;
  logic            trap_ret;
  logic            halt_req;

  logic [XLEN-1:0] pc_out;
  logic            pc_valid;
  logic [XLEN-1:0] epc_out;
  logic [DW-1:0]   trap_depth;
  logic            trap_err;
  logic            halted;

  modport master (
    output start, stall, redirect_valid, redirect_target,
           trap_req, trap_ret, halt_req,
    input  pc_out, pc_valid, epc_out, trap_depth, trap_err, halted
  );

  modport slave (
    input  start, stall, redirect_valid, redirect_target,
           trap_req, trap_ret, halt_req,
    output pc_out, pc_valid, epc_out, trap_depth, trap_err, halted
  );

endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Purpose : program-counter sequencer with IDLE/RUN/HALT control, branch
//           redirect, and a nested-trap return-address (EPC) stack.
// Parameters:
//   XLEN         pc width in bits
//   RESET_VECTOR pc after reset (4-byte aligned)
//   TRAP_VECTOR  pc on trap entry (4-byte aligned)
//   EPC_DEPTH    number of nested trap return addresses (>= 1)
// Configuration macro:
//   PC_EPC_STACK_EN  defined   -> EPC is an EPC_DEPTH-entry LIFO
//                    undefined -> EPC is a single register (depth 1);
//                                 trap_depth keeps its declared width
// Ports:
//   clk   sole clock, rising edge
//   reset asynchronous, active-low
//   bus   pc_sequencer_if.slave (requests in, pc/EPC status out)
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter int              EPC_DEPTH    = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam int DW = $clog2(EPC_DEPTH + 1);

`ifdef PC_EPC_STACK_EN
  localparam int STACK_DEPTH = (EPC_DEPTH < 1) ? 1 : EPC_DEPTH;
`else
  localparam int STACK_DEPTH = 1;
`endif

  localparam logic [DW-1:0] FULL_COUNT = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ACT_HOLD     = 3'd0,
    ACT_SEQ      = 3'd1,
    ACT_REDIRECT = 3'd2,
    ACT_TRAP     = 3'd3,
    ACT_RET      = 3'd4
  } action_e;

  state_e          state_q, state_d;
  action_e         action;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q [STACK_DEPTH];
  logic [XLEN-1:0] epc_d [STACK_DEPTH];
  logic [DW-1:0]   depth_q, depth_d;
  logic            trap_err_q, trap_err_d;

  logic [XLEN-1:0] pc_plus4;
  logic            stack_empty;
  logic            stack_full;

  assign pc_plus4    = pc_q + XLEN'(4);
  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q >= FULL_COUNT);

  // Control: pick the next state and the single pc action for this cycle.
  // Dropping start wins over everything in RUN; halt_req is honoured even
  // while stalled; otherwise a stall freezes pc and EPC.
  always_comb begin
    state_d = state_q;
    action  = ACT_HOLD;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.start) begin
          state_d = IDLE;
        end else if (bus.halt_req) begin
          state_d = HALT;
        end else if (!bus.stall) begin
          if (bus.trap_req) begin
            action = ACT_TRAP;
          end else if (bus.trap_ret) begin
            action = ACT_RET;
          end else if (bus.redirect_valid) begin
            action = ACT_REDIRECT;
          end else begin
            action = ACT_SEQ;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: entry 0 of epc is always the top of the LIFO, so push shifts
  // entries down and pop shifts them up. Vacated slots are cleared so an
  // empty stack holds only zeros.
  always_comb begin
    pc_d       = pc_q;
    depth_d    = depth_q;
    trap_err_d = trap_err_q;
    epc_d      = epc_q;
    unique case (action)
      ACT_SEQ: begin
        pc_d = pc_plus4;
      end
      ACT_REDIRECT: begin
        pc_d = {bus.redirect_target[XLEN-1:2], 2'b00};
      end
      ACT_TRAP: begin
        pc_d = TRAP_VECTOR;
        if (stack_full) begin
          trap_err_d = 1'b1;
        end else begin
          for (int i = STACK_DEPTH - 1; i > 0; i--) begin
            epc_d[i] = epc_q[i-1];
          end
          epc_d[0] = pc_plus4;
          depth_d  = depth_q + DW'(1);
        end
      end
      ACT_RET: begin
        if (stack_empty) begin
          trap_err_d = 1'b1;
          pc_d       = pc_plus4;
        end else begin
          pc_d = epc_q[0];
          for (int i = 0; i < STACK_DEPTH - 1; i++) begin
            epc_d[i] = epc_q[i+1];
          end
          epc_d[STACK_DEPTH-1] = '0;
          depth_d              = depth_q - DW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // State registers; reset discards the whole EPC stack regardless of what
  // was pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      depth_q    <= '0;
      trap_err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        epc_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      depth_q    <= depth_d;
      trap_err_q <= trap_err_d;
      epc_q      <= epc_d;
    end
  end

  // Outputs come from registers; pc_valid alone looks at stall directly.
  assign bus.pc_out     = pc_q;
  assign bus.epc_out    = stack_empty ? '0 : epc_q[0];
  assign bus.trap_depth = depth_q;
  assign bus.trap_err   = trap_err_q;
  assign bus.halted     = (state_q == HALT);
  assign bus.pc_valid   = (state_q == RUN) && !bus.stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Purpose : self-checking bench for pc_sequencer. A behavioural reference
//           model (queue-based EPC stack) predicts each cycle's outputs; the
//           prediction is queued when stimulus is driven and compared after
//           the clock edge that produces it.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int          XLEN         = 32;
  localparam int          EPC_DEPTH    = 4;
  localparam logic [31:0] RESET_VECTOR = 32'h0;
  localparam logic [31:0] TRAP_VECTOR  = 32'h100;

`ifdef PC_EPC_STACK_EN
  localparam int EFF_DEPTH = EPC_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic reset;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  pc_sequencer_if #(.XLEN(XLEN), .EPC_DEPTH(EPC_DEPTH)) bus ();

  pc_sequencer #(
    .XLEN        (XLEN),
    .RESET_VECTOR(RESET_VECTOR),
    .TRAP_VECTOR (TRAP_VECTOR),
    .EPC_DEPTH   (EPC_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] epc;
    int          depth;
    bit          err;
    bit          halted;
  } expT;

  expT         sbQueue[$];
  int          passCount  = 0;
  int          checkCount = 0;
  int          modelState;
  logic [31:0] modelPc;
  logic [31:0] modelStack[$];
  bit          modelErr;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  function automatic expT snapshot(input string tag);
    expT e;
    e.tag    = tag;
    e.pc     = modelPc;
    e.epc    = (modelStack.size() > 0) ? modelStack[$] : 32'h0;
    e.depth  = modelStack.size();
    e.err    = modelErr;
    e.halted = (modelState == M_HALT);
    return e;
  endfunction

  task automatic compareNow(input expT e);
    checkOutput({e.tag, ".pc"},     64'(bus.pc_out),     64'(e.pc));
    checkOutput({e.tag, ".epc"},    64'(bus.epc_out),    64'(e.epc));
    checkOutput({e.tag, ".depth"},  64'(bus.trap_depth), 64'(e.depth));
    checkOutput({e.tag, ".err"},    64'(bus.trap_err),   64'(e.err));
    checkOutput({e.tag, ".halted"}, 64'(bus.halted),     64'(e.halted));
  endtask

  // Reference model of one clock edge.
  task automatic modelStep(input bit st, input bit stl, input bit rv,
                           input logic [31:0] tgt, input bit tr,
                           input bit rt, input bit hl);
    case (modelState)
      M_IDLE: if (st) modelState = M_RUN;
      M_RUN: begin
        if (!st) modelState = M_IDLE;
        else if (hl) modelState = M_HALT;
        else if (!stl) begin
          if (tr) begin
            if (modelStack.size() < EFF_DEPTH) modelStack.push_back(modelPc + 32'd4);
            else modelErr = 1'b1;
            modelPc = TRAP_VECTOR;
          end else if (rt) begin
            if (modelStack.size() > 0) modelPc = modelStack.pop_back();
            else begin
              modelErr = 1'b1;
              modelPc  = modelPc + 32'd4;
            end
          end else if (rv) begin
            modelPc = tgt & 32'hFFFF_FFFC;
          end else begin
            modelPc = modelPc + 32'd4;
          end
        end
      end
      default: ;
    endcase
  endtask

  // Drive one cycle of stimulus at the falling edge, check the combinational
  // pc_valid, queue the model's prediction, then compare after the rising edge.
  task automatic applyStimulus(input string tag, input bit st, input bit stl,
                               input bit rv, input logic [31:0] tgt,
                               input bit tr, input bit rt, input bit hl);
    bus.start           = st;
    bus.stall           = stl;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    bus.trap_req        = tr;
    bus.trap_ret        = rt;
    bus.halt_req        = hl;
    #1;
    checkOutput({tag, ".valid"}, 64'(bus.pc_valid),
                64'((modelState == M_RUN) && !stl));
    modelStep(st, stl, rv, tgt, tr, rt, hl);
    sbQueue.push_back(snapshot(tag));
    @(posedge clk);
    #1;
    if (sbQueue.size() == 0) checkOutput({tag, ".sb"}, 64'(0), 64'(1));
    else compareNow(sbQueue.pop_front());
    @(negedge clk);
  endtask

  task automatic runCycle(input string tag);
    applyStimulus(tag, 1, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic redirectTo(input string tag, input logic [31:0] tgt);
    applyStimulus(tag, 1, 0, 1, tgt, 0, 0, 0);
  endtask

  task automatic trapEnter(input string tag);
    applyStimulus(tag, 1, 0, 0, 32'h0, 1, 0, 0);
  endtask

  task automatic trapReturn(input string tag);
    applyStimulus(tag, 1, 0, 0, 32'h0, 0, 1, 0);
  endtask

  // Assert reset wherever we are, check the asynchronous effect before any
  // clock edge, then release on the next falling edge.
  task automatic assertReset(input string tag);
    reset               = 1'b0;
    bus.start           = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.trap_req        = 1'b0;
    bus.trap_ret        = 1'b0;
    bus.halt_req        = 1'b0;
    #1;
    modelState = M_IDLE;
    modelPc    = RESET_VECTOR;
    modelStack.delete();
    modelErr   = 1'b0;
    compareNow(snapshot(tag));
    checkOutput({tag, ".valid"}, 64'(bus.pc_valid), 64'(0));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    $display("[TB] pc_sequencer bench, effective EPC depth %0d", EFF_DEPTH);
    @(negedge clk);
    assertReset("por");

    // Stays IDLE without start, then start held: pc 0, 0, 4, 8.
    applyStimulus("idleHold", 0, 0, 0, 32'h0, 0, 0, 0);
    applyStimulus("boot", 1, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("boot.pcConst", 64'(bus.pc_out), 64'(32'h0));
    runCycle("seq4");
    runCycle("seq8");
    checkOutput("pcAt8", 64'(bus.pc_out), 64'(32'h8));

    // Trap beats redirect in the same cycle.
    applyStimulus("trapRedir", 1, 0, 1, 32'h203, 1, 0, 0);
    checkOutput("trapRedir.pcConst",  64'(bus.pc_out),     64'(32'h100));
    checkOutput("trapRedir.epcConst", 64'(bus.epc_out),    64'(32'hC));
    checkOutput("trapRedir.depConst", 64'(bus.trap_depth), 64'(1));
    trapReturn("ret1");
    checkOutput("ret1.pcConst", 64'(bus.pc_out), 64'(32'hC));

    // Redirect alignment, then return with an empty stack.
    redirectTo("redir203", 32'h203);
    checkOutput("redir203.pcConst", 64'(bus.pc_out), 64'(32'h200));
    redirectTo("to40", 32'h40);
    trapReturn("retEmpty");
    checkOutput("retEmpty.pcConst",  64'(bus.pc_out),   64'(32'h44));
    checkOutput("retEmpty.errConst", 64'(bus.trap_err), 64'(1));
    runCycle("errSticky");

    // Nested traps past the stack depth, then unwind in LIFO order.
    assertReset("rstNest");
    applyStimulus("bootNest", 1, 0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      redirectTo("nestRedir", 32'h1000 * (i + 1));
      trapEnter("nestTrap");
    end
    checkOutput("nestSat.depConst", 64'(bus.trap_depth), 64'(EFF_DEPTH));
    checkOutput("nestSat.errConst", 64'(bus.trap_err),   64'(1));
    for (int i = 0; i < 4; i++) begin
      trapReturn("unwind");
    end
    checkOutput("unwind.depConst", 64'(bus.trap_depth), 64'(0));

    // Wrap modulo 2^32.
    redirectTo("toTop", 32'hFFFF_FFFC);
    runCycle("wrap");
    checkOutput("wrap.pcConst", 64'(bus.pc_out), 64'(32'h0));

    // Dropping start ignores requests; IDLE ignores requests too.
    applyStimulus("stopWithTrap", 0, 0, 0, 32'h0, 1, 0, 0);
    applyStimulus("idleReqs", 0, 0, 1, 32'h80, 1, 1, 0);
    applyStimulus("reboot", 1, 0, 0, 32'h0, 0, 0, 0);

    // Stall holds pc and EPC against trap requests.
    trapEnter("preStall");
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stallTrap", 1, 1, 0, 32'h0, 1, 0, 0);
    end
    checkOutput("stall.pcConst",  64'(bus.pc_out),     64'(32'h100));
    checkOutput("stall.depConst", 64'(bus.trap_depth), 64'(1));

    // Reset mid-trap, between clock edges.
    #2;
    assertReset("rstMidTrap");

    // Halt while stalled, then frozen until reset.
    applyStimulus("bootHalt", 1, 0, 0, 32'h0, 0, 0, 0);
    runCycle("preHalt");
    applyStimulus("stallHalt", 1, 1, 0, 32'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("haltFrozen", 1, 0, 1, 32'h500, 1, 0, 0);
    end
    applyStimulus("haltNoStart", 0, 0, 0, 32'h0, 0, 1, 0);
    checkOutput("halt.pcConst",  64'(bus.pc_out), 64'(32'h4));
    checkOutput("halt.hltConst", 64'(bus.halted), 64'(1));
    assertReset("rstFinal");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
